ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter.
- Pairs with the board's PS/2 receive path (ps2_decoder) on the same PS2_CLK/PS2_DAT lines.
- Sends command bytes to the keyboard, e.g. 0xED set-LEDs followed by a mask byte, or 0xFF reset.
- Drives both lines open-drain through output-enables, runs in the CLOCK_50 domain, and reports done or error per byte.

Parameters:
- INHIBIT_CYCLES, 6000: clocks that ps2_clk is held low before the request (120 us at 50 MHz; must be >= 100 us).
- TIMEOUT_CYCLES, 750000: clocks from the start of the request to completion before abort (15 ms).
- FILTER_LEN, 8: consecutive equal synchronized samples needed to accept a line level change.

Ports:
- clk, in, 1: system clock (CLOCK_50).
- reset, in, 1: asynchronous, active-high reset.
- tx_data, in, 8: byte to send.
- tx_valid, in, 1: request; byte accepted when tx_valid && tx_ready.
- tx_ready, out, 1: high only in IDLE.
- ps2_clk_async, in, 1: raw PS2_CLK pin level.
- ps2_data_async, in, 1: raw PS2_DAT pin level.
- ps2_clk_oe, out, 1: 1 = pull PS2_CLK low; 0 = release.
- ps2_data_oe, out, 1: 1 = pull PS2_DAT low; 0 = release.
- busy, out, 1: high outside IDLE; the receiver ignores the lines while it is high.
- tx_done, out, 1: one-cycle pulse after the device ACK is received.
- tx_error, out, 1: one-cycle pulse on timeout or missing ACK.

Behaviour:
- Reset values: state IDLE; tx_ready=1; busy=0; both OEs=0; tx_done=0; tx_error=0; all counters 0.
- Input conditioning:
  - Each input passes through a 2-FF synchronizer, then a FILTER_LEN filter.
  - fall = filtered clk 1->0. This is a one-cycle strobe.
- Accept: on tx_valid && tx_ready, latch tx_data into shift[7:0]. Parity bit = ~^tx_data (odd parity). Go to INHIBIT.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0.
  - After INHIBIT_CYCLES: ps2_data_oe=1 (start bit 0), then ps2_clk_oe=0 on the next cycle. Go to DATA with bit counter=0.
  - The timeout counter starts on entry to INHIBIT.
- DATA:
  - On each fall, drive ps2_data_oe = ~shift[0], shift right, increment the counter.
  - On the fall that drives bit 7, go to PARITY.
- PARITY: on the next fall, ps2_data_oe = ~parity. Go to STOP.
- STOP: on the next fall, ps2_data_oe=0 (release = stop bit 1). Go to ACK.
- ACK: on the next fall (the 11th), sample filtered data.
  - 0 -> WAIT_IDLE.
  - 1 -> ERROR.
- WAIT_IDLE: wait until filtered clk=1 and data=1, then pulse tx_done and return to IDLE.
- ERROR: both OEs=0, pulse tx_error, return to IDLE.
- Timeout: in any state other than IDLE, reaching TIMEOUT_CYCLES forces ERROR. This takes priority over a fall in the same cycle.
- OE changes occur only in the cycle after fall. ps2_clk_oe is never 1 outside INHIBIT.
- tx_valid during busy is ignored; there is no queue, and the caller holds tx_valid.
- Assertion of reset mid-frame:
  - Both OEs are released immediately (asynchronously).
  - No done or error pulse is emitted.
  - The device times out on its own side.
- tx_done and tx_error are never asserted in the same cycle.
- tx_ready returns to 1 in the cycle after either pulse.

Decomposition:
- ps2_pkg holds:
  - The state enum: IDLE, INHIBIT, DATA, PARITY, STOP, ACK, WAIT_IDLE, ERROR.
  - Command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ECHO=8'hEE.
  - Response constants RSP_ACK=8'hFA, RSP_RESEND=8'hFE.
- Sub-module ps2_line_filter: synchronizer plus FILTER_LEN filter. It is instantiated twice here and is reusable by ps2_decoder.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs.
  - ps2_clk_oe low for exactly 6000 cycles.
  - Sampled frame = 0, 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - tx_done pulses once; tx_ready returns to 1.
- Send 0x07 and then 0x00.
  - 0x07 has parity bit 0.
  - 0x00 has parity bit 1.
  - Both complete with tx_done.
- Device model releases data on the 11th clock (no ACK) -> tx_error one-cycle pulse, no tx_done, both OEs 0.
- Device never clocks after the request -> tx_error exactly at TIMEOUT_CYCLES after tx accept; lines released.
- Assert reset at bit 4 of 0xFF -> OEs 0 in the same cycle, tx_ready=1 after reset deasserts, no pulses.
- Pulse tx_valid with 0xAA while busy during a 0xED frame -> ignored; only the 0xED frame appears on the wire.
- 3-cycle glitch on ps2_clk_async with FILTER_LEN=8 -> no bit advance.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks (transmitter and decoder).
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE,
        ERROR
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a run-length filter for one open-drain PS/2 line.
// The filtered level only follows the pin after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_async,
    output logic line_filt
);

    localparam int            CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // Lines idle high, so everything resets to the released level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            line_filt <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_async};
            if (sync_q[1] == line_filt) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                line_filt <= sync_q[1];
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/8 data/parity/stop
// on device-generated clock falls, checks the device ACK and reports done or error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_async,
    input  logic       ps2_data_async,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    import ps2_pkg::*;

    localparam int            IW       = $clog2(INHIBIT_CYCLES + 1);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t state_q, state_d;

    logic          clk_filt;
    logic          dat_filt;
    logic          clk_filt_q;
    logic          fall;

    logic [IW-1:0] inh_cnt_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic          data_drv_q;

    logic          accept;
    logic          inh_last;
    logic          tmo_hit;
    logic          lines_idle;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk        (clk),
        .reset      (reset),
        .line_async (ps2_clk_async),
        .line_filt  (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk        (clk),
        .reset      (reset),
        .line_async (ps2_data_async),
        .line_filt  (dat_filt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_filt_q <= 1'b1;
        end else begin
            clk_filt_q <= clk_filt;
        end
    end

    assign fall       = clk_filt_q & ~clk_filt;
    assign accept     = tx_valid && (state_q == IDLE);
    assign inh_last   = (state_q == INHIBIT) && (inh_cnt_q == INH_LAST);
    assign tmo_hit    = (state_q != IDLE) && (tmo_cnt_q == TMO_LAST);
    assign lines_idle = clk_filt && dat_filt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timeout wins over any fall seen in the same cycle.
    always_comb begin
        state_d = state_q;
        if (tmo_hit && (state_q != ERROR)) begin
            state_d = ERROR;
        end else begin
            case (state_q)
                IDLE:      if (tx_valid) state_d = INHIBIT;
                INHIBIT:   if (inh_last) state_d = DATA;
                DATA:      if (fall && (bit_cnt_q == 3'd7)) state_d = PARITY;
                PARITY:    if (fall) state_d = STOP;
                STOP:      if (fall) state_d = ACK;
                ACK:       if (fall) state_d = dat_filt ? ERROR : WAIT_IDLE;
                WAIT_IDLE: if (lines_idle) state_d = IDLE;
                ERROR:     state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // data_drv_q holds the bit currently presented on the wire (1 = pull low).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            data_drv_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == IDLE) ? '0 : tmo_cnt_q + TW'(1);
            inh_cnt_q <= (state_q == INHIBIT) ? inh_cnt_q + IW'(1) : '0;

            if (accept) begin
                shift_q  <= tx_data;
                parity_q <= odd_parity(tx_data);
            end

            case (state_q)
                IDLE: data_drv_q <= 1'b0;
                INHIBIT: begin
                    bit_cnt_q  <= '0;
                    data_drv_q <= 1'b1;
                end
                DATA: begin
                    if (fall && !tmo_hit) begin
                        data_drv_q <= ~shift_q[0];
                        shift_q    <= {1'b0, shift_q[7:1]};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                    end
                end
                PARITY: if (fall && !tmo_hit) data_drv_q <= ~parity_q;
                STOP:   if (fall && !tmo_hit) data_drv_q <= 1'b0;
                default: data_drv_q <= 1'b0;
            endcase
        end
    end

    // Outputs decode from the asynchronously reset state, so reset releases both lines at once.
    always_comb begin
        tx_ready    = 1'b0;
        busy        = 1'b1;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = inh_last;
            end
            DATA, PARITY, STOP: ps2_data_oe = data_drv_q;
            WAIT_IDLE: tx_done = lines_idle && !tmo_hit;
            ERROR: tx_error = 1'b1;
            default: ;
        endcase
    end

endmodule
